wb_port_arbiter: RTL
====================

# wb_port_arbiter

Shares the single register-file write port of the 16-bit pipeline between the ALU result path and the memory-load result path. Each source presents a valid/ready request carrying a destination register and data. The block grants one request per cycle, with fixed memory priority and a starvation guard for the ALU. The granted write is presented to the register file on a registered write port one cycle later.

## Interface
- DATA_W, 16, width of write data
- ADDR_W, 3, width of register address (2**ADDR_W registers; register 0 hardwired zero)
- STARVE_LIMIT, 3, consecutive denied ALU cycles before ALU gets priority; legal range 1..15
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU write request
- alu_addr  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- alu_ready  output  1  ALU request granted this cycle (combinational)
- mem_valid  input  1  load write request
- mem_addr  input  ADDR_W  load destination register
- mem_data  input  DATA_W  load data
- mem_ready  output  1  load request granted this cycle (combinational)
- rf_we  output  1  register-file write enable (registered)
- rf_waddr  output  ADDR_W  register-file write address (registered)
- rf_wdata  output  DATA_W  register-file write data (registered)
- starve_cnt  output  4  current ALU denial count (debug)

## Operation
- A handshake completes on a rising edge where valid=1 and ready=1. A requester holds valid, addr and data stable until ready=1.
- At most one of alu_ready and mem_ready is 1 in any cycle. Ready is 0 whenever the corresponding valid is 0.
- The priority FSM has two states:
  - MEM_FIRST (reset state): if mem_valid, grant mem; else if alu_valid, grant alu.
  - ALU_FIRST: if alu_valid, grant alu; else if mem_valid, grant mem.
- Starvation counter behaviour:
  - Increments on each cycle where alu_valid=1 and alu is not granted, saturating at STARVE_LIMIT.
  - Clears to 0 on an alu grant or whenever alu_valid=0.
- State transitions:
  - MEM_FIRST -> ALU_FIRST when the counter's next value equals STARVE_LIMIT.
  - ALU_FIRST -> MEM_FIRST on an alu grant, or when alu_valid=0.
- A granted handshake loads rf_waddr and rf_wdata from the winner on the next edge. rf_we is set to 1 unless the winner's addr is 0.
- A request to register 0 is still handshaken (ready=1, consumed) but produces rf_we=0. rf_waddr and rf_wdata still update.
- In cycles with no grant, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- If both sources target the same register in the same cycle, only the winner is written. The loser is written in a later cycle, so program order between the two sources is the requesters' responsibility.

## Timing
- Reset values (asynchronous, while rst=0):
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - starve_cnt=0
  - state=MEM_FIRST
  - alu_ready=0, mem_ready=0
- Latency: 1 cycle from the handshake edge to the rf_* outputs, which stay valid for one cycle.
- Throughput: one write per cycle. With continuous contention and STARVE_LIMIT=N, grants repeat as N mem grants followed by 1 alu grant.
- Reset asserted mid-operation discards any in-flight grant. Outputs return to reset values immediately, without waiting for a clock edge.
- Deassertion of rst is synchronous to clk externally; the first grant can occur on the first edge after deassertion.

## Configuration
- WB_BYPASS_EN defined adds three ports:
  - byp_raddr, input, ADDR_W
  - byp_hit, output, 1
  - byp_data, output, DATA_W
- byp_hit = rf_we && (rf_waddr == byp_raddr) && (byp_raddr != 0), combinational. byp_data = rf_wdata when hit, else 0. This forwards the write being committed this cycle to a same-cycle register read.
- WB_BYPASS_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset: drive rst=0 mid-stream with both valids high. Required: rf_we=0, rf_waddr=0, rf_wdata=0, starve_cnt=0 immediately. After release, the first grant goes to mem.
- Single source: mem_valid=1, mem_addr=5, mem_data=16'hBEEF, alu idle. Required: mem_ready=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=16'hBEEF.
- Contention: both valid continuously for 8 cycles, STARVE_LIMIT=3. Required grant sequence M,M,M,A,M,M,M,A; starve_cnt reads 0,1,2,3,0,1,2,3.
- Register 0: alu_valid=1, alu_addr=0, alu_data=16'h1234. Required: alu_ready=1; next cycle rf_we=0 and rf_wdata=16'h1234.
- Valid drop: alu denied 2 cycles, then alu_valid=0 for 1 cycle. Required: starve_cnt returns to 0 and state stays MEM_FIRST.
- Bypass (WB_BYPASS_EN defined): commit r3=16'h00AA, byp_raddr=3 -> byp_hit=1, byp_data=16'h00AA. With byp_raddr=4 -> byp_hit=0, byp_data=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: memory-first priority with an ALU starvation guard; 1-cycle registered write, ready is same-cycle grant.
// Optional same-cycle read bypass of the committing write when WB_BYPASS_EN is defined.
module wb_port_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 3,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        starve_cnt
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] byp_raddr,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {MEM_FIRST, ALU_FIRST} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              grant_alu, grant_mem;

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    // Readies are forced low while reset is held so no grant escapes asynchronously.
    if (rst) begin
      if (state_q == ALU_FIRST) begin
        if (alu_valid)      grant_alu = 1'b1;
        else if (mem_valid) grant_mem = 1'b1;
      end else begin
        if (mem_valid)      grant_mem = 1'b1;
        else if (alu_valid) grant_alu = 1'b1;
      end
    end
  end

  always_comb begin
    if (!alu_valid || grant_alu) cnt_d = 4'd0;
    else if (cnt_q >= LIMIT)     cnt_d = LIMIT;
    else                         cnt_d = cnt_q + 4'd1;

    state_d = state_q;
    case (state_q)
      MEM_FIRST: if (cnt_d == LIMIT) state_d = ALU_FIRST;
      ALU_FIRST: if (grant_alu || !alu_valid) state_d = MEM_FIRST;
      default:   state_d = MEM_FIRST;
    endcase

    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_alu) begin
      rf_we_d    = (alu_addr != '0);
      rf_waddr_d = alu_addr;
      rf_wdata_d = alu_data;
    end else if (grant_mem) begin
      rf_we_d    = (mem_addr != '0);
      rf_waddr_d = mem_addr;
      rf_wdata_d = mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= MEM_FIRST;
      cnt_q      <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign alu_ready  = grant_alu;
  assign mem_ready  = grant_mem;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign starve_cnt = cnt_q;

`ifdef WB_BYPASS_EN
  assign byp_hit  = rf_we_q && (rf_waddr_q == byp_raddr) && (byp_raddr != '0);
  assign byp_data = byp_hit ? rf_wdata_q : '0;
`endif

endmodule
